// File: rtl/iter_divider.sv
// iter_divider: multi-cycle restoring radix-2 integer divider for the EX1 stage.
// Signed mode truncates toward zero; the remainder follows the dividend's sign.
// Divide-by-zero and (optionally) |dividend| < |divisor| finish without iterating.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for en; operands captured on acceptance
// ITER   | one quotient bit per cycle, MSB first
// FIX    | apply result signs, write quotient/remainder registers
// DONE   | ready pulse; pipeline advances this cycle
module iter_divider #(
  parameter int WIDTH     = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             flush_exception,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             stall_divider,
  output logic             ready
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // acc holds the unsigned dividend bits still to be consumed (top) and the
  // quotient bits produced so far (bottom); after WIDTH steps it is the quotient.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  // special results (divide-by-zero, early-out) are already final in acc/rem
  logic             special_q, special_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             ready_q, ready_d;

  logic [WIDTH-1:0] abs_dvd, abs_dvs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             trial_ok;

  // Operand magnitudes; |MIN| wraps to 2^(WIDTH-1), which is correct as unsigned.
  assign abs_dvd = (sign && dividend[WIDTH-1]) ? (-dividend) : dividend;
  assign abs_dvs = (sign && divisor[WIDTH-1])  ? (-divisor)  : divisor;

  // One restoring step: the shifted partial remainder is WIDTH+1 bits wide,
  // and when it is >= b the difference always fits in WIDTH bits.
  assign shifted  = {rem_q, acc_q[WIDTH-1]};
  assign trial_ok = (shifted >= {1'b0, b_q});
  assign diff     = shifted[WIDTH-1:0] - b_q;

  assign stall_divider = rstn & ~flush_exception &
                         (((state_q == S_IDLE) & en) |
                          (state_q == S_ITER) |
                          (state_q == S_FIX));

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign ready     = ready_q;

  // Next-state and datapath update for every state; flush overrides everything.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    b_d         = b_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    special_d   = special_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    ready_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en) begin
          qneg_d = sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          rneg_d = sign & dividend[WIDTH-1];
          b_d    = abs_dvs;
          cnt_d  = CNT_INIT;
          if (divisor == '0) begin
            special_d = 1'b1;
            acc_d     = '1;
            rem_d     = dividend;
            state_d   = S_FIX;
          end else if (EARLY_OUT && (abs_dvd < abs_dvs)) begin
            special_d = 1'b1;
            acc_d     = '0;
            rem_d     = dividend;
            state_d   = S_FIX;
          end else begin
            special_d = 1'b0;
            acc_d     = abs_dvd;
            rem_d     = '0;
            state_d   = S_ITER;
          end
        end
      end
      S_ITER: begin
        acc_d = {acc_q[WIDTH-2:0], trial_ok};
        rem_d = trial_ok ? diff : shifted[WIDTH-1:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (special_q) begin
          quotient_d  = acc_q;
          remainder_d = rem_q;
        end else begin
          quotient_d  = qneg_q ? (-acc_q) : acc_q;
          remainder_d = rneg_q ? (-rem_q) : rem_q;
        end
        ready_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (flush_exception) begin
      state_d     = S_IDLE;
      ready_d     = 1'b0;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
    end
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      b_q         <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      special_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      b_q         <= b_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      special_q   <= special_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      ready_q     <= ready_d;
    end
  end

endmodule
